iis_adc_rx: RTL and testbench

IIS_ADC_RX -- requirements
Module: iis_adc_rx

---
 rtl/audio_pkg.sv | 27 ++
 rtl/sample_fifo.sv | 72 +++++++
 rtl/iis_adc_rx.sv | 170 +++++++++++++++++
 tb/tb_iis_adc_rx.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// ---------------------------------------------------------------------------
// audio_pkg -- definitions shared by the codec capture and playback paths.
//
// Contents:
//   WORD_BITS   : bits per stereo frame word {L, R}
//   CH_BITS     : bits per channel
//   CNT_BITS    : width of a counter that indexes the bits of one word
//   cap_state_e : capture FSM state encoding (IDLE, HUNT, SHIFT)
//   is_last_bit : true when a bit index points at the final bit of a word
// ---------------------------------------------------------------------------
package audio_pkg;

    localparam int WORD_BITS = 32;
    localparam int CH_BITS   = 16;
    localparam int CNT_BITS  = $clog2(WORD_BITS);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HUNT  = 2'd1,
        ST_SHIFT = 2'd2
    } cap_state_e;

    function automatic logic is_last_bit(input logic [CNT_BITS-1:0] idx);
        return idx == CNT_BITS'(WORD_BITS - 1);
    endfunction

endpackage

// File: rtl/sample_fifo.sv
// ---------------------------------------------------------------------------
// sample_fifo -- synchronous first-word-fall-through FIFO.
//
// Ports:
//   clk_50m, rst_n : clock, asynchronous active-low reset
//   wr_en, wr_data : push request and data; accepted when not full, or when
//                    full and a pop happens in the same cycle
//   rd_en          : pop request; ignored while empty
//   rd_data        : head entry, valid whenever empty = 0 (fall-through)
//   full, empty    : occupancy status
// ---------------------------------------------------------------------------
module sample_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk_50m,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int            AW       = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_rd;
    logic             do_wr;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_rd   = rd_en & ~empty;
    // A pop frees the slot the push needs, so a full FIFO can still accept.
    assign do_wr   = wr_en & (~full | do_rd);
    assign rd_data = mem[rd_ptr];

    // NOTE: the storage array has no reset; only pointers and count do. Stale
    // contents are unreachable because readers qualify rd_data with empty.
    always_ff @(posedge clk_50m) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_wr, do_rd})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/iis_adc_rx.sv
// ---------------------------------------------------------------------------
// iis_adc_rx -- capture path for a codec ADC in DSP mode A (codec is master).
//
// Ports:
//   clk_50m, rst_n        : system clock, asynchronous active-low reset
//   en                    : capture enable; a rising edge clears the flags
//   IIS_BCLK              : codec bit clock, asynchronous, <= 12.5 MHz
//   IIS_ADCLRC            : frame sync, high for one BCLK period
//   IIS_ADCDAT            : serial data, MSB first
//   smp_data              : head word {L[15:0], R[15:0]}, 0 while empty
//   smp_valid, smp_ready  : valid/ready hand-off of captured words
//   overflow              : sticky, a completed word was dropped (FIFO full)
//   frame_err             : sticky, frame sync arrived mid-word
//   word_cnt              : number of words written into the FIFO (wraps)
// ---------------------------------------------------------------------------
module iis_adc_rx
    import audio_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk_50m,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 IIS_BCLK,
    input  logic                 IIS_ADCLRC,
    input  logic                 IIS_ADCDAT,
    output logic [WORD_BITS-1:0] smp_data,
    output logic                 smp_valid,
    input  logic                 smp_ready,
    output logic                 overflow,
    output logic                 frame_err,
    output logic [15:0]          word_cnt
);

    // Synchronizers: bit 0 is the first flop, bit 2 the third stage.
    logic [2:0] bclk_sync;
    logic [2:0] lrc_sync;
    logic [2:0] dat_sync;

    logic bclk_rise;
    logic lrc_bit;
    logic dat_bit;
    logic lrc_prev;
    logic frame_start;

    cap_state_e            state;
    logic [CNT_BITS-1:0]   bit_cnt;
    logic [WORD_BITS-1:0]  shift_reg;
    logic                  word_done;

    logic                  fifo_push;
    logic                  fifo_pop;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [WORD_BITS-1:0]  fifo_rd_data;

    // NOTE: every clocked register here uses non-blocking assignment so all
    // flops update together at the edge, independent of statement order.
    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            bclk_sync <= '0;
            lrc_sync  <= '0;
            dat_sync  <= '0;
        end else begin
            bclk_sync <= {bclk_sync[1:0], IIS_BCLK};
            lrc_sync  <= {lrc_sync[1:0],  IIS_ADCLRC};
            dat_sync  <= {dat_sync[1:0],  IIS_ADCDAT};
        end
    end

    // The edge is seen between the second and third BCLK stages. The third
    // stage of LRC/DAT holds the line state from just before that rising
    // edge, well after the codec launched it on the preceding falling edge.
    assign bclk_rise   = bclk_sync[1] & ~bclk_sync[2];
    assign lrc_bit     = lrc_sync[2];
    assign dat_bit     = dat_sync[2];
    assign frame_start = bclk_rise & lrc_bit & ~lrc_prev;

    assign fifo_push = word_done;
    assign fifo_pop  = smp_valid & smp_ready;

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            bit_cnt   <= '0;
            shift_reg <= '0;
            lrc_prev  <= 1'b0;
            word_done <= 1'b0;
            frame_err <= 1'b0;
            overflow  <= 1'b0;
            word_cnt  <= '0;
        end else begin
            word_done <= 1'b0;

            if (bclk_rise) begin
                lrc_prev <= lrc_bit;
            end

            if (!en) begin
                // Dropping enable abandons any partial word; flags hold.
                state   <= ST_IDLE;
                bit_cnt <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        state     <= ST_HUNT;
                        overflow  <= 1'b0;
                        frame_err <= 1'b0;
                    end
                    ST_HUNT: begin
                        if (frame_start) begin
                            state   <= ST_SHIFT;
                            bit_cnt <= '0;
                        end
                    end
                    ST_SHIFT: begin
                        if (frame_start) begin
                            // Early sync: drop the partial word and treat this
                            // edge as the start of a new frame.
                            frame_err <= 1'b1;
                            bit_cnt   <= '0;
                        end else if (bclk_rise) begin
                            shift_reg <= {shift_reg[WORD_BITS-2:0], dat_bit};
                            if (is_last_bit(bit_cnt)) begin
                                word_done <= 1'b1;
                                bit_cnt   <= '0;
                                state     <= ST_HUNT;
                            end else begin
                                bit_cnt <= bit_cnt + CNT_BITS'(1);
                            end
                        end
                    end
                    default: begin
                        state   <= ST_IDLE;
                        bit_cnt <= '0;
                    end
                endcase
            end

            // Placed after the enable handling so a drop in the same cycle as
            // a flag clear is still recorded.
            if (fifo_push && fifo_full && !fifo_pop) begin
                overflow <= 1'b1;
            end
            if (fifo_push && (!fifo_full || fifo_pop)) begin
                word_cnt <= word_cnt + 16'd1;
            end
        end
    end

    // shift_reg holds the completed word during the push cycle; the next
    // BCLK edge is at least four clk_50m cycles away.
    sample_fifo #(
        .WIDTH (WORD_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_50m (clk_50m),
        .rst_n   (rst_n),
        .wr_en   (fifo_push),
        .wr_data (shift_reg),
        .rd_en   (fifo_pop),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign smp_valid = ~fifo_empty;
    assign smp_data  = fifo_empty ? '0 : fifo_rd_data;

endmodule

// File: tb/tb_iis_adc_rx.sv
// ---------------------------------------------------------------------------
// tb_iis_adc_rx -- self-checking bench for iis_adc_rx.
//
// Drives a DSP-mode-A codec model (BCLK ~3.1 MHz, edges placed 1 ns after a
// clk_50m edge) and compares every delivered word with a queue of expected
// words pushed when each frame is sent.
// ---------------------------------------------------------------------------
module tb_iis_adc_rx;

    localparam int HALF = 8;   // clk_50m cycles per BCLK half period

    logic        clk_50m;
    logic        rst_n;
    logic        en;
    logic        IIS_BCLK;
    logic        IIS_ADCLRC;
    logic        IIS_ADCDAT;
    logic [31:0] smp_data;
    logic        smp_valid;
    logic        smp_ready;
    logic        overflow;
    logic        frame_err;
    logic [15:0] word_cnt;

    int          vectors;
    int          miscompares;
    int          xfer_cnt;
    int          exp_cnt;
    logic [31:0] exp_q [$];

    iis_adc_rx #(.FIFO_DEPTH(4)) dut (
        .clk_50m    (clk_50m),
        .rst_n      (rst_n),
        .en         (en),
        .IIS_BCLK   (IIS_BCLK),
        .IIS_ADCLRC (IIS_ADCLRC),
        .IIS_ADCDAT (IIS_ADCDAT),
        .smp_data   (smp_data),
        .smp_valid  (smp_valid),
        .smp_ready  (smp_ready),
        .overflow   (overflow),
        .frame_err  (frame_err),
        .word_cnt   (word_cnt)
    );

    initial clk_50m = 1'b0;
    always #10 clk_50m = ~clk_50m;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One BCLK period: falling edge launches LRC/DAT, then rising edge.
    // mode 1: check smp_valid timing after the rising edge (edge k + 3/4).
    // mode 2: pulse smp_ready for exactly the FIFO write cycle.
    task automatic bclk_bit(input logic lrc, input logic dat, input int mode);
        @(posedge clk_50m); #1;
        IIS_BCLK   = 1'b0;
        IIS_ADCLRC = lrc;
        IIS_ADCDAT = dat;
        repeat (HALF) @(posedge clk_50m);
        #1;
        IIS_BCLK = 1'b1;
        case (mode)
            1: begin
                repeat (3) @(posedge clk_50m);
                #1 check("valid_at_c1", smp_valid, 1'b0);
                @(posedge clk_50m);
                #1 check("valid_at_c2", smp_valid, 1'b1);
                repeat (HALF - 5) @(posedge clk_50m);
            end
            2: begin
                repeat (3) @(posedge clk_50m);
                #1 smp_ready = 1'b1;
                @(posedge clk_50m);
                #1 smp_ready = 1'b0;
                repeat (HALF - 5) @(posedge clk_50m);
            end
            default: repeat (HALF - 1) @(posedge clk_50m);
        endcase
    endtask

    // Frame sync bit, then nbits data bits MSB first, then idle bits.
    task automatic send_frame(input logic [31:0] word, input int nbits, input int idle,
                              input int mode, input logic keep);
        if (keep) exp_q.push_back(word);
        bclk_bit(1'b1, 1'b0, 0);
        for (int i = 0; i < nbits; i++) begin
            bclk_bit(1'b0, word[31-i], (i == nbits - 1) ? mode : 0);
        end
        for (int i = 0; i < idle; i++) begin
            bclk_bit(1'b0, 1'b0, 0);
        end
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            @(posedge clk_50m);
            n++;
        end
        if (n >= 2000) check("drain_timeout", 32'(exp_q.size()), 32'd0);
        repeat (4) @(posedge clk_50m);
        #1;
    endtask

    // A transfer happens at the next edge when valid and ready are both high.
    always @(negedge clk_50m) begin
        if (rst_n && smp_valid && smp_ready) begin
            xfer_cnt++;
            check("sb_avail", exp_q.size() != 0, 1'b1);
            if (exp_q.size() != 0) check("sb_data", smp_data, exp_q.pop_front());
        end
    end

    initial begin
        int base;
        vectors     = 0;
        miscompares = 0;
        xfer_cnt    = 0;
        exp_cnt     = 0;
        rst_n       = 1'b0;
        en          = 1'b0;
        IIS_BCLK    = 1'b1;
        IIS_ADCLRC  = 1'b0;
        IIS_ADCDAT  = 1'b0;
        smp_ready   = 1'b0;

        // Reset values
        repeat (5) @(posedge clk_50m);
        #1;
        check("rst_valid",     smp_valid, 1'b0);
        check("rst_data",      smp_data,  32'h0);
        check("rst_overflow",  overflow,  1'b0);
        check("rst_frame_err", frame_err, 1'b0);
        check("rst_word_cnt",  word_cnt,  16'd0);
        rst_n = 1'b1;
        @(posedge clk_50m); #1;
        en = 1'b1;
        repeat (4) @(posedge clk_50m);
        #1;

        // Single word, latency to smp_valid
        smp_ready = 1'b1;
        send_frame(32'h1234ABCD, 32, 4, 1, 1'b1);
        exp_cnt++;
        check("t1_word_cnt", word_cnt, 16'(exp_cnt));
        check("t1_empty", smp_valid, 1'b0);

        // Overflow: 5 frames into a 4-deep FIFO with no consumer
        smp_ready = 1'b0;
        base = xfer_cnt;
        for (int i = 0; i < 5; i++) begin
            send_frame(32'h01010101 * (i + 1), 32, 2, 0, i < 4);
            if (i < 4) exp_cnt++;
            if (i == 3) begin
                repeat (6) @(posedge clk_50m);
                #1 check("t2_no_ovf_at_full", overflow, 1'b0);
            end
        end
        repeat (8) @(posedge clk_50m);
        #1;
        check("t2_overflow", overflow,  1'b1);
        check("t2_word_cnt", word_cnt,  16'(exp_cnt));
        check("t2_valid",    smp_valid, 1'b1);
        check("t2_head",     smp_data,  exp_q[0]);
        repeat (20) @(posedge clk_50m);
        #1 check("t2_head_hold", smp_data, exp_q[0]);
        smp_ready = 1'b1;
        wait_drain();
        check("t2_xfers", 32'(xfer_cnt - base), 32'd4);
        check("t2_drained", smp_valid, 1'b0);

        // Re-enable clears the flags in the HUNT entry cycle
        en = 1'b0;
        repeat (3) @(posedge clk_50m);
        #1 check("t3_ovf_hold", overflow, 1'b1);
        en = 1'b1;
        @(posedge clk_50m);
        #1;
        check("t3_ovf_clr", overflow,  1'b0);
        check("t3_err_clr", frame_err, 1'b0);

        // Early frame sync after 20 bits
        send_frame(32'hBAD0BAD0, 20, 0, 0, 1'b0);
        send_frame(32'hCAFE0001, 32, 4, 0, 1'b1);
        exp_cnt++;
        wait_drain();
        check("t3_frame_err", frame_err, 1'b1);
        check("t3_word_cnt",  word_cnt,  16'(exp_cnt));

        // Enable dropped after 10 bits, then re-raised
        send_frame(32'h77777777, 10, 0, 0, 1'b0);
        en = 1'b0;
        repeat (4) @(posedge clk_50m);
        #1 check("t4_err_hold", frame_err, 1'b1);
        en = 1'b1;
        @(posedge clk_50m);
        #1 check("t4_err_clr", frame_err, 1'b0);
        send_frame(32'h00FF8001, 32, 4, 0, 1'b1);
        exp_cnt++;
        wait_drain();
        check("t4_word_cnt", word_cnt, 16'(exp_cnt));
        check("t4_frame_err", frame_err, 1'b0);

        // Full FIFO with a pop in the write cycle
        smp_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            send_frame(32'h50000000 + 32'(i), 32, 2, 0, 1'b1);
            exp_cnt++;
        end
        send_frame(32'h50000004, 32, 2, 2, 1'b1);
        exp_cnt++;
        repeat (8) @(posedge clk_50m);
        #1;
        check("t5_overflow", overflow, 1'b0);
        check("t5_word_cnt", word_cnt, 16'(exp_cnt));
        smp_ready = 1'b1;
        wait_drain();
        check("t5_drained", smp_valid, 1'b0);

        // Reset pulsed mid-frame with a word still buffered
        smp_ready = 1'b0;
        send_frame(32'hDEAD0000, 32, 2, 0, 1'b0);
        send_frame(32'h89ABCDEF, 15, 0, 0, 1'b0);
        @(posedge clk_50m); #1;
        rst_n = 1'b0;
        @(posedge clk_50m); #1;
        check("t6_valid",     smp_valid, 1'b0);
        check("t6_data",      smp_data,  32'h0);
        check("t6_overflow",  overflow,  1'b0);
        check("t6_frame_err", frame_err, 1'b0);
        check("t6_word_cnt",  word_cnt,  16'd0);
        rst_n     = 1'b1;
        exp_cnt   = 0;
        smp_ready = 1'b1;
        for (int i = 0; i < 17; i++) begin
            bclk_bit(1'b0, 1'b1, 0);
        end
        send_frame(32'h5A5AC3C3, 32, 4, 0, 1'b1);
        exp_cnt++;
        wait_drain();
        check("t6_word_cnt_after", word_cnt, 16'(exp_cnt));
        check("sb_left", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
